// File: rtl/serial_rx.sv
// Serial word receiver: rebuilds an MSB-first frame from serial_tx using the shared cnt timebase.
// Each bit is sampled mid-period; the frame-start line level is checked and flagged via err.
module serial_rx #(
  parameter int unsigned          P_DATA_W  = 256,
  parameter logic [P_DATA_W-1:0]  P_RX_INIT = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  input  logic                y0,
  input  logic [7:0]          nbits,
  input  logic [31:0]         n0,
  input  logic [31:0]         n1,
  input  logic [31:0]         n2,
  input  logic [31:0]         n3,
  input  logic [31:0]         cnt,
  output logic [P_DATA_W-1:0] data,
  output logic                valid,
  output logic                err,
  output logic                busy
);

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StTail
  } state_e;

  state_e state_q, state_d;

  logic [P_DATA_W-1:0] sr_q, sr_d;
  logic [P_DATA_W-1:0] data_q, data_d;
  logic [P_DATA_W-1:0] sr_shift;
  logic [7:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          bit_cnt_inc;
  logic [31:0]         nxt_q, nxt_d;
  logic [31:0]         tail_q, tail_d;
  logic                err_r_q, err_r_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;

  logic [31:0] i_n1, i_n2, period, half;
  logic [7:0]  nb;

  // Zero-valued settings are promoted to 1 so the bit period can never collapse.
  always_comb begin
    i_n1   = (n1 == 32'd0) ? 32'd1 : n1;
    i_n2   = (n2 == 32'd0) ? 32'd1 : n2;
    period = i_n1 + i_n2;
    half   = period >> 1;
    nb     = (nbits == 8'd0) ? 8'd1 : nbits;
  end

  // Shift form keeps P_DATA_W == 1 legal; older bits fall off the top for long frames.
  assign sr_shift    = (sr_q << 1) | P_DATA_W'(din);
  assign bit_cnt_inc = bit_cnt_q + 8'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      data_q    <= P_RX_INIT;
      bit_cnt_q <= 8'd0;
      nxt_q     <= 32'd0;
      tail_q    <= 32'd0;
      err_r_q   <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      nxt_q     <= nxt_d;
      tail_q    <= tail_d;
      err_r_q   <= err_r_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    nxt_d     = nxt_q;
    tail_d    = tail_q;
    err_r_d   = err_r_q;
    err_d     = err_q;
    valid_d   = 1'b0;

    case (state_q)
      StIdle: begin
        sr_d      = '0;
        bit_cnt_d = 8'd0;
        if (cnt == n0) begin
          err_r_d = (din != y0);
          nxt_d   = cnt + i_n1 + half;
          state_d = StSample;
        end
      end
      StSample: begin
        if (cnt == nxt_q) begin
          sr_d      = sr_shift;
          bit_cnt_d = bit_cnt_inc;
          nxt_d     = nxt_q + period;
          if (bit_cnt_inc == nb) begin
            data_d  = sr_shift;
            valid_d = 1'b1;
            err_d   = err_r_q;
            // Hold until the transmitter finishes the last bit period plus its tail.
            tail_d  = cnt + (period - half) + n3;
            state_d = StTail;
          end
        end
      end
      StTail: begin
        if (cnt == tail_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy  = (state_q != StIdle);
    data  = data_q;
    valid = valid_q;
    err   = err_q;
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: a behavioural serial_tx line model drives din from cnt, and a
// scoreboard queue holds the expected word, err and valid timing of each frame.
module tb_serial_rx;

  localparam int unsigned W = 256;

  logic          clk;
  logic          rst;
  logic          din;
  logic          y0;
  logic [7:0]    nbits;
  logic [31:0]   n0, n1, n2, n3, cnt;
  logic [W-1:0]  data;
  logic          valid, err, busy;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    logic [31:0]  vcnt;
  } exp_t;

  exp_t         sb_q[$];
  int           total  = 0;
  int           passed = 0;
  logic [W-1:0] word_g = '0;
  logic         bad_g  = 1'b0;

  serial_rx #(
    .P_DATA_W (W),
    .P_RX_INIT('0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .y0   (y0),
    .nbits(nbits),
    .n0   (n0),
    .n1   (n1),
    .n2   (n2),
    .n3   (n3),
    .cnt  (cnt),
    .data (data),
    .valid(valid),
    .err  (err),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Transmitter line model: start level at n0, then nb bit periods of i_n1+i_n2, MSB first.
  function automatic logic din_model(input logic [31:0] c);
    logic [31:0] i1, i2, p, rel, rel2;
    int          nb, k;
    i1  = (n1 == 0) ? 32'd1 : n1;
    i2  = (n2 == 0) ? 32'd1 : n2;
    p   = i1 + i2;
    nb  = (nbits == 0) ? 1 : int'(nbits);
    rel = c - n0;
    if (rel == 0) return bad_g ? ~y0 : y0;
    if (rel < i1) return y0;
    rel2 = rel - i1;
    if (rel2 < 32'(nb) * p) begin
      k = int'(rel2 / p);
      return word_g[nb - 1 - k];
    end
    return y0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cnt = cnt + 32'd1;
    din = din_model(cnt);
  endtask

  task automatic set_cnt(input logic [31:0] v);
    cnt = v;
    din = din_model(cnt);
  endtask

  // Runs one frame from the current cnt, checking busy right at and after the tail compare.
  task automatic run_frame(input logic [W-1:0] w, input logic bad, input string tag);
    logic [31:0] i1, i2, p, h, last, t;
    int          nb, k;
    exp_t        e;
    i1   = (n1 == 0) ? 32'd1 : n1;
    i2   = (n2 == 0) ? 32'd1 : n2;
    p    = i1 + i2;
    h    = p >> 1;
    nb   = (nbits == 0) ? 1 : int'(nbits);
    last = n0 + i1 + h + 32'(nb - 1) * p;
    t    = last + (p - h) + n3;
    word_g = w;
    bad_g  = bad;
    din    = din_model(cnt);
    e.data = w;
    e.err  = bad;
    e.vcnt = last + 32'd1;
    sb_q.push_back(e);
    k = 0;
    while (cnt != t && k < 5000) begin
      step();
      k++;
    end
    check({tag, "_in_time"}, W'(k < 5000), W'(1));
    check({tag, "_busy_hi"}, W'(busy), W'(1));
    step();
    check({tag, "_busy_lo"}, W'(busy), W'(0));
    check({tag, "_sb_empty"}, W'(sb_q.size()), W'(0));
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", W'(valid), W'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("data", data, e.data);
        check("err", W'(err), W'(e.err));
        check("valid_cnt", W'(cnt), W'(e.vcnt));
      end
    end
  end

  initial begin
    logic [W-1:0] rw;
    int           k;
    rst   = 1'b1;
    y0    = 1'b0;
    nbits = 8'd8;
    n0    = 32'd4;
    n1    = 32'd2;
    n2    = 32'd2;
    n3    = 32'd1;
    cnt   = 32'd0;
    din   = 1'b0;
    #2;
    check("rst_data", data, '0);
    check("rst_valid", W'(valid), W'(0));
    check("rst_err", W'(err), W'(0));
    check("rst_busy", W'(busy), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic 8-bit loopback frame.
    set_cnt(32'd0);
    run_frame(W'(8'hA5), 1'b0, "t1");

    // nbits=0 and n1=n2=0 degenerate to a single bit with P=2.
    nbits = 8'd0;
    n1    = 32'd0;
    n2    = 32'd0;
    set_cnt(32'd0);
    run_frame(W'(1), 1'b0, "t2");

    // Wrong line level at frame start flags err, next clean frame clears it.
    nbits = 8'd8;
    n1    = 32'd2;
    n2    = 32'd2;
    set_cnt(32'd0);
    run_frame(W'(8'h3C), 1'b1, "t3");
    set_cnt(32'd0);
    run_frame(W'(8'h5A), 1'b0, "t3b");

    // Reset mid-frame aborts without a valid pulse.
    set_cnt(32'd0);
    word_g = W'(8'hA5);
    bad_g  = 1'b0;
    din    = din_model(cnt);
    k = 0;
    while (cnt != 32'd20 && k < 100) begin
      step();
      k++;
    end
    check("t4_busy_mid", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    check("t4_rst_data", data, '0);
    check("t4_rst_busy", W'(busy), W'(0));
    check("t4_rst_valid", W'(valid), W'(0));
    step();
    step();
    rst = 1'b0;
    set_cnt(32'd0);
    run_frame(W'(8'hA5), 1'b0, "t4");

    // Longest frame with thresholds wrapping through 2^32.
    nbits = 8'd255;
    n0    = 32'h20;
    n1    = 32'd1;
    n2    = 32'd1;
    n3    = 32'd0;
    for (int i = 0; i < W / 32; i++) rw[i*32 +: 32] = $urandom;
    rw[255] = 1'b0;
    set_cnt(32'hFFFF_FF00);
    run_frame(rw, 1'b0, "t5");

    // Back-to-back frames, each starting on the first cnt after the previous tail.
    nbits = 8'd8;
    n0    = 32'd4;
    n1    = 32'd3;
    n2    = 32'd2;
    n3    = 32'd0;
    set_cnt(32'd0);
    run_frame(W'(8'hC3), 1'b0, "t6a");
    n0 = cnt;
    n3 = 32'd5;
    run_frame(W'(8'h81), 1'b0, "t6b");
    n0 = cnt;
    n3 = 32'd0;
    run_frame(W'(8'h7E), 1'b0, "t6c");
    repeat (10) step();
    check("final_sb_empty", W'(sb_q.size()), W'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
